// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit_pkg
// Description : Shared constants and types for the EX-stage forwarding and
//               load-use hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_forward_unit_pkg;

    // Register address width of the integer register file
    localparam int REG_W = 5;

    // Hard-wired zero register; never a forwarding source or a hazard
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // Operand-mux select encoding; bit 1 dominates inside the mux
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 2'b00;
    localparam fwd_sel_t FWD_EXMEM   = 2'b01;
    localparam fwd_sel_t FWD_MEMWB   = 2'b10;

endpackage : hazard_forward_unit_pkg
`default_nettype wire

// File: rtl/hazard_forward_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit_if
// Description : ID-stage hazard inputs plus stall and operand-mux select
//               outputs of the forwarding unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_forward_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;

    // Forwarding unit: produces the stall and mux selects
    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
        input  id_reg_write, id_mem_read, flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_count
    );

    // Pipeline datapath: feeds ID fields and consumes the selects
    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
        output id_reg_write, id_mem_read, flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_count
    );

endinterface : hazard_forward_unit_if
`default_nettype wire

// File: rtl/hazard_forward_unit_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Priority compare for one EX operand: newest producer (MEM)
//               beats WB, register zero never forwards.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select #(
    parameter int REG_W = 5
) (
    input  wire logic [REG_W-1:0] i_ex_src,
    input  wire logic             i_ex_uses,
    input  wire logic [REG_W-1:0] i_mem_dest,
    input  wire logic             i_mem_reg_write,
    input  wire logic [REG_W-1:0] i_wb_dest,
    input  wire logic             i_wb_reg_write,
    output logic      [1:0]       o_sel
);
    import hazard_forward_unit_pkg::*;

    localparam logic [REG_W-1:0] c_zero = REG_W'(REG_ZERO);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_ex_uses && i_mem_reg_write &&
                       (i_mem_dest != c_zero) && (i_mem_dest == i_ex_src);
    assign w_wb_hit  = i_ex_uses && i_wb_reg_write &&
                       (i_wb_dest != c_zero) && (i_wb_dest == i_ex_src);

    // Pick the youngest in-flight producer of the EX source register
    always_comb begin
        o_sel = FWD_REGFILE;
        if (w_mem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule : fwd_select
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Shadow EX/MEM/WB pipeline of register-write info, operand
//               forwarding selects and one-cycle load-use stall with counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input wire logic              clk,
    input wire logic              rst_n,
    hazard_forward_unit_if.master bus
);
    import hazard_forward_unit_pkg::*;

    localparam logic [REG_W-1:0] c_zero    = REG_W'(REG_ZERO);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // EX shadow
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;
    logic             r_ex_uses_rs;
    logic             r_ex_uses_rt;
    logic [REG_W-1:0] r_ex_dest;
    logic             r_ex_reg_write;
    logic             r_ex_mem_read;
    // MEM / WB shadow
    logic [REG_W-1:0] r_mem_dest;
    logic             r_mem_reg_write;
    logic [REG_W-1:0] r_wb_dest;
    logic             r_wb_reg_write;

    logic [CNT_W-1:0] r_stall_count;

    logic w_load_use;
    logic w_stall;
    logic w_bubble;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Load in EX whose destination is read by the instruction in ID
    assign w_load_use = r_ex_mem_read && r_ex_reg_write && (r_ex_dest != c_zero) &&
                        ((bus.id_uses_rs && (bus.id_rs == r_ex_dest)) ||
                         (bus.id_uses_rt && (bus.id_rt == r_ex_dest)));

    // A flushed ID instruction is discarded, so it never counts as a stall
    assign w_stall  = w_load_use && !bus.flush;
    assign w_bubble = w_load_use || bus.flush;

    // Advance the shadow pipeline, inserting a bubble into EX when needed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
            r_ex_uses_rs    <= 1'b0;
            r_ex_uses_rt    <= 1'b0;
            r_ex_dest       <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_dest      <= '0;
            r_mem_reg_write <= 1'b0;
            r_wb_dest       <= '0;
            r_wb_reg_write  <= 1'b0;
        end else begin
            r_ex_rs         <= bus.id_rs;
            r_ex_rt         <= bus.id_rt;
            r_ex_dest       <= bus.id_dest;
            r_ex_uses_rs    <= bus.id_uses_rs   && !w_bubble;
            r_ex_uses_rt    <= bus.id_uses_rt   && !w_bubble;
            r_ex_reg_write  <= bus.id_reg_write && !w_bubble;
            r_ex_mem_read   <= bus.id_mem_read  && !w_bubble;
            r_mem_dest      <= r_ex_dest;
            r_mem_reg_write <= r_ex_reg_write;
            r_wb_dest       <= r_mem_dest;
            r_wb_reg_write  <= r_mem_reg_write;
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .i_ex_src        (r_ex_rs),
        .i_ex_uses       (r_ex_uses_rs),
        .i_mem_dest      (r_mem_dest),
        .i_mem_reg_write (r_mem_reg_write),
        .i_wb_dest       (r_wb_dest),
        .i_wb_reg_write  (r_wb_reg_write),
        .o_sel           (w_fwd_a)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .i_ex_src        (r_ex_rt),
        .i_ex_uses       (r_ex_uses_rt),
        .i_mem_dest      (r_mem_dest),
        .i_mem_reg_write (r_mem_reg_write),
        .i_wb_dest       (r_wb_dest),
        .i_wb_reg_write  (r_wb_reg_write),
        .o_sel           (w_fwd_b)
    );

    assign bus.stall       = w_stall;
    assign bus.fwd_a_sel   = w_fwd_a;
    assign bus.fwd_b_sel   = w_fwd_b;
    assign bus.stall_count = r_stall_count;

endmodule : hazard_forward_unit
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_unit
// Description : Directed bench for the forwarding / load-use hazard unit.
//               A second instance with a 4-bit counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;

    int n_pass;
    int n_total;

    hazard_forward_unit_if #(.REG_W(5), .CNT_W(16)) bus ();
    hazard_forward_unit_if #(.REG_W(5), .CNT_W(4))  sbus ();

    assign bus.id_rs         = id_rs;
    assign bus.id_rt         = id_rt;
    assign bus.id_uses_rs    = id_uses_rs;
    assign bus.id_uses_rt    = id_uses_rt;
    assign bus.id_dest       = id_dest;
    assign bus.id_reg_write  = id_reg_write;
    assign bus.id_mem_read   = id_mem_read;
    assign bus.flush         = flush;
    assign sbus.id_rs        = id_rs;
    assign sbus.id_rt        = id_rt;
    assign sbus.id_uses_rs   = id_uses_rs;
    assign sbus.id_uses_rt   = id_uses_rt;
    assign sbus.id_dest      = id_dest;
    assign sbus.id_reg_write = id_reg_write;
    assign sbus.id_mem_read  = id_mem_read;
    assign sbus.flush        = flush;

    hazard_forward_unit #(.REG_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hazard_forward_unit #(.REG_W(5), .CNT_W(4)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns later
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt,
                          input logic [4:0] dest, input logic rw, input logic mr);
        id_rs = rs; id_uses_rs = urs;
        id_rt = rt; id_uses_rt = urt;
        id_dest = dest; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic nop();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;
    endtask

    task automatic drain();
        nop();
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        set_id(5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'b1);
        repeat (2) cycle();
        nop();
        #1;
        n_total++;
        if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bus.stall);
        else n_pass++;
        n_total++;
        if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00)
            $display("FAIL reset_sel: got a=%b b=%b expected 00/00", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        n_total++;
        if (bus.stall_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", bus.stall_count);
        else n_pass++;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_exmem_forward();
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$1,$2
        cycle();
        set_id(5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);   // sub $4,$3,$5
        n_total++;
        #1;
        if (bus.stall !== 1'b0) $display("FAIL exmem_nostall: got %b expected 0", bus.stall);
        else n_pass++;
        cycle();
        nop();
        n_total++;
        if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b00)
            $display("FAIL exmem_sel: got a=%b b=%b expected 01/00", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        drain();
    endtask

    task automatic test_double_producer();
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        cycle();
        set_id(5'd4, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        cycle();
        set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);   // or $6,$3,$3
        cycle();
        nop();
        n_total++;
        if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b01)
            $display("FAIL double_mem_priority: got a=%b b=%b expected 01/01", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        drain();
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        cycle();
        nop();
        cycle();
        set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);   // or $6,$3,$3
        cycle();
        nop();
        n_total++;
        if (bus.fwd_a_sel !== 2'b10 || bus.fwd_b_sel !== 2'b10)
            $display("FAIL gap_wb_forward: got a=%b b=%b expected 10/10", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        drain();
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        c0 = bus.stall_count;
        set_id(5'd29, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);  // lw $2,0($29)
        cycle();
        set_id(5'd2, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);   // add $7,$2,$1
        #1;
        n_total++;
        if (bus.stall !== 1'b1) $display("FAIL loaduse_stall: got %b expected 1", bus.stall);
        else n_pass++;
        cycle();
        n_total++;
        if (bus.stall !== 1'b0) $display("FAIL loaduse_one_cycle: got %b expected 0", bus.stall);
        else n_pass++;
        n_total++;
        if (bus.stall_count !== c0 + 16'd1)
            $display("FAIL loaduse_count: got %0d expected %0d", bus.stall_count, c0 + 16'd1);
        else n_pass++;
        cycle();
        nop();
        n_total++;
        if (bus.fwd_a_sel !== 2'b10 || bus.fwd_b_sel !== 2'b00)
            $display("FAIL loaduse_sel: got a=%b b=%b expected 10/00", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        drain();
    endtask

    task automatic test_reg_zero();
        set_id(5'd29, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);  // lw $0
        cycle();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);   // add $1,$0,$0
        #1;
        n_total++;
        if (bus.stall !== 1'b0) $display("FAIL zero_stall: got %b expected 0", bus.stall);
        else n_pass++;
        cycle();
        nop();
        n_total++;
        if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00)
            $display("FAIL zero_load_sel: got a=%b b=%b expected 00/00", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        drain();
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // addi $0,$1,imm
        cycle();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);   // use $0
        cycle();
        nop();
        n_total++;
        if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00)
            $display("FAIL zero_alu_sel: got a=%b b=%b expected 00/00", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush_stall();
        logic [15:0] c0;
        c0 = bus.stall_count;
        set_id(5'd29, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);  // lw $2
        cycle();
        set_id(5'd2, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);   // add $7,$2,$2
        flush = 1'b1;
        #1;
        n_total++;
        if (bus.stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", bus.stall);
        else n_pass++;
        cycle();
        nop();
        #1;
        n_total++;
        if (bus.stall_count !== c0)
            $display("FAIL flush_count: got %0d expected %0d", bus.stall_count, c0);
        else n_pass++;
        n_total++;
        if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00)
            $display("FAIL flush_bubble_sel: got a=%b b=%b expected 00/00", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        drain();
    endtask

    task automatic test_saturation();
        logic [15:0] c0;
        c0 = bus.stall_count;
        // lw $2,0($2) repeatedly: each depends on the previous, stalling every other cycle
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
        cycle();
        repeat (40) cycle();
        nop();
        #1;
        n_total++;
        if (bus.stall_count !== c0 + 16'd20)
            $display("FAIL chain_count: got %0d expected %0d", bus.stall_count, c0 + 16'd20);
        else n_pass++;
        n_total++;
        if (sbus.stall_count !== 4'hF)
            $display("FAIL saturate_count: got %h expected f", sbus.stall_count);
        else n_pass++;
        cycle();
        n_total++;
        if (sbus.stall_count !== 4'hF)
            $display("FAIL saturate_hold: got %h expected f", sbus.stall_count);
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid_hazard();
        set_id(5'd29, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);  // lw $2
        cycle();
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // use $2
        #1;
        n_total++;
        if (bus.stall !== 1'b1) $display("FAIL midrst_pre_stall: got %b expected 1", bus.stall);
        else n_pass++;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        n_total++;
        if (bus.stall !== 1'b0) $display("FAIL midrst_stall: got %b expected 0", bus.stall);
        else n_pass++;
        n_total++;
        if (bus.stall_count !== 16'd0) $display("FAIL midrst_count: got %0d expected 0", bus.stall_count);
        else n_pass++;
        cycle();
        nop();
        n_total++;
        if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00)
            $display("FAIL midrst_sel: got a=%b b=%b expected 00/00", bus.fwd_a_sel, bus.fwd_b_sel);
        else n_pass++;
        drain();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_exmem_forward();
        test_double_producer();
        test_load_use();
        test_reg_zero();
        test_flush_stall();
        test_saturation();
        test_reset_mid_hazard();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hazard_forward_unit
`default_nettype wire
